adc_serial_sampler: RTL and testbench

ADC_SERIAL_SAMPLER -- requirements
Module: adc_serial_sampler

---
 rtl/audio_pkg.sv | 19 +
 rtl/sync_2ff.sv | 22 ++
 rtl/adc_serial_sampler.sv | 178 +++++++++++++++++
 tb/tb_adc_serial_sampler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared defaults and FSM encoding for the serial audio ADC front end.
package audio_pkg;
    localparam int DEF_CLK_DIV       = 25;
    localparam int DEF_CS_SETUP_CYC  = 70;
    localparam int DEF_CONV_CYCLES   = 1000;
    localparam int DEF_SAMPLE_PERIOD = 2500;

    localparam int CNT_W       = 16;
    localparam int SAMPLE_W    = 8;
    localparam int SCLK_HALVES = 2 * SAMPLE_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        DONE  = 3'd3,
        CONV  = 3'd4
    } adc_state_t;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/adc_serial_sampler.sv
// Periodically reads one 8-bit sample from a serial ADC: chip select, setup delay,
// eight SCLK periods shifting data MSB first, then a conversion gap.
module adc_serial_sampler
    import audio_pkg::*;
#(
    parameter int CLK_DIV       = DEF_CLK_DIV,
    parameter int CS_SETUP_CYC  = DEF_CS_SETUP_CYC,
    parameter int CONV_CYCLES   = DEF_CONV_CYCLES,
    parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                adc_dout,
    output logic                adc_cs_n,
    output logic                adc_sclk,
    output logic [SAMPLE_W-1:0] audio_data,
    output logic                data_valid,
    output logic                busy,
    output logic                overrun
);
    adc_state_t r_state;
    adc_state_t w_stateNext;

    logic [CNT_W-1:0]    r_periodCnt;
    logic [CNT_W-1:0]    r_waitCnt;
    logic [7:0]          r_divCnt;
    logic [3:0]          r_halfCnt;
    logic [SAMPLE_W-1:0] r_shiftReg;

    logic                r_csN;
    logic                r_sclk;
    logic [SAMPLE_W-1:0] r_audio;
    logic                r_valid;
    logic                r_busy;
    logic                r_overrun;

    logic                w_csNNext;
    logic                w_sclkNext;
    logic [SAMPLE_W-1:0] w_audioNext;
    logic                w_validNext;
    logic                w_busyNext;
    logic                w_overrunNext;

    logic w_doutSync;
    logic w_tick;
    logic w_setupEnd;
    logic w_convEnd;
    logic w_halfEnd;
    logic w_shiftEnd;
    logic w_sclkRise;

    sync_2ff u_doutSync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (adc_dout),
        .o_q   (w_doutSync)
    );

    // Period counter parks at zero while disabled so re-enabling ticks at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_periodCnt <= '0;
        end else if (!en || r_periodCnt == CNT_W'(SAMPLE_PERIOD - 1)) begin
            r_periodCnt <= '0;
        end else begin
            r_periodCnt <= r_periodCnt + CNT_W'(1);
        end
    end

    assign w_tick     = en && (r_periodCnt == '0);
    assign w_setupEnd = (r_state == SETUP) && (r_waitCnt == CNT_W'(CS_SETUP_CYC - 1));
    assign w_convEnd  = (r_state == CONV) && (r_waitCnt == CNT_W'(CONV_CYCLES - 1));
    assign w_halfEnd  = (r_state == SHIFT) && (r_divCnt == 8'(CLK_DIV - 1));
    assign w_shiftEnd = w_halfEnd && (r_halfCnt == 4'(SCLK_HALVES - 1));
    assign w_sclkRise = w_halfEnd && !r_sclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waitCnt <= '0;
        end else if (w_stateNext != r_state) begin
            r_waitCnt <= '0;
        end else if (r_state == SETUP || r_state == CONV) begin
            r_waitCnt <= r_waitCnt + CNT_W'(1);
        end else begin
            r_waitCnt <= '0;
        end
    end

    // Each SCLK half-period is CLK_DIV cycles; r_halfCnt counts the 16 halves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_divCnt  <= '0;
            r_halfCnt <= '0;
        end else if (r_state != SHIFT) begin
            r_divCnt  <= '0;
            r_halfCnt <= '0;
        end else if (w_halfEnd) begin
            r_divCnt  <= '0;
            r_halfCnt <= r_halfCnt + 4'd1;
        end else begin
            r_divCnt  <= r_divCnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shiftReg <= '0;
        end else if (w_sclkRise) begin
            r_shiftReg <= {r_shiftReg[SAMPLE_W-2:0], w_doutSync};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        unique case (r_state)
            IDLE:    if (w_tick)     w_stateNext = SETUP;
            SETUP:   if (w_setupEnd) w_stateNext = SHIFT;
            SHIFT:   if (w_shiftEnd) w_stateNext = DONE;
            DONE:                    w_stateNext = CONV;
            CONV:    if (w_convEnd)  w_stateNext = IDLE;
            default:                 w_stateNext = IDLE;
        endcase
    end

    // Ticks that land mid-frame are dropped but leave a sticky overrun flag.
    always_comb begin
        w_csNNext     = r_csN;
        w_sclkNext    = 1'b0;
        w_audioNext   = r_audio;
        w_validNext   = 1'b0;
        w_busyNext    = (w_stateNext != IDLE);
        w_overrunNext = r_overrun | (w_tick && (r_state != IDLE));
        unique case (r_state)
            IDLE:  if (w_tick) w_csNNext = 1'b0;
            SHIFT: w_sclkNext = w_halfEnd ? ~r_sclk : r_sclk;
            DONE: begin
                w_csNNext   = 1'b1;
                w_audioNext = r_shiftReg;
                w_validNext = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csN     <= 1'b1;
            r_sclk    <= 1'b0;
            r_audio   <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_csN     <= w_csNNext;
            r_sclk    <= w_sclkNext;
            r_audio   <= w_audioNext;
            r_valid   <= w_validNext;
            r_busy    <= w_busyNext;
            r_overrun <= w_overrunNext;
        end
    end

    assign adc_cs_n   = r_csN;
    assign adc_sclk   = r_sclk;
    assign audio_data = r_audio;
    assign data_valid = r_valid;
    assign busy       = r_busy;
    assign overrun    = r_overrun;
endmodule

// File: tb/tb_adc_serial_sampler.sv
// Directed/random bench for adc_serial_sampler with behavioural ADC and frame-timing model.
module tb_adc_serial_sampler;
    localparam int D  = 4;
    localparam int S  = 3;
    localparam int C  = 20;
    localparam int PA = 100;
    localparam int PB = 60;
    localparam int FRAME_LEN = 1 + S + 16 * D + 1 + C;
    localparam int VALID_LAT = S + 16 * D + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic enA = 1'b0;
    logic enB = 1'b0;
    logic doutA = 1'b0;
    logic doutB = 1'b0;
    logic csA, sclkA, validA, busyA, ovrA;
    logic csB, sclkB, validB, busyB, ovrB;
    logic [7:0] audioA, audioB;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adc_serial_sampler #(.CLK_DIV(D), .CS_SETUP_CYC(S), .CONV_CYCLES(C), .SAMPLE_PERIOD(PA)) dutA (
        .clk(clk), .rst_n(rst_n), .en(enA), .adc_dout(doutA), .adc_cs_n(csA), .adc_sclk(sclkA),
        .audio_data(audioA), .data_valid(validA), .busy(busyA), .overrun(ovrA)
    );

    adc_serial_sampler #(.CLK_DIV(D), .CS_SETUP_CYC(S), .CONV_CYCLES(C), .SAMPLE_PERIOD(PB)) dutB (
        .clk(clk), .rst_n(rst_n), .en(enB), .adc_dout(doutB), .adc_cs_n(csB), .adc_sclk(sclkB),
        .audio_data(audioB), .data_valid(validB), .busy(busyB), .overrun(ovrB)
    );

    // ADC models: latch a sample at cs_n fall, present MSB, advance on each SCLK fall.
    logic [7:0] planA[$];
    logic [7:0] expA[$];
    logic [7:0] expB[$];
    logic [7:0] curA = 8'h00;
    logic [7:0] curB = 8'h00;
    int bitA = 7;
    int bitB = 7;

    always @(negedge csA) begin
        curA = (planA.size() > 0) ? planA.pop_front() : 8'($urandom_range(0, 255));
        expA.push_back(curA);
        bitA = 7;
        doutA = curA[7];
    end
    always @(negedge sclkA) if (!csA && bitA > 0) begin
        bitA = bitA - 1;
        doutA = curA[bitA];
    end

    always @(negedge csB) begin
        curB = 8'($urandom_range(0, 255));
        expB.push_back(curB);
        bitB = 7;
        doutB = curB[7];
    end
    always @(negedge sclkB) if (!csB && bitB > 0) begin
        bitB = bitB - 1;
        doutB = curB[bitB];
    end

    // Event monitors sampled on the inactive clock edge.
    int fallA[$];
    int validCycA[$];
    logic [7:0] validDatA[$];
    int risesAtValidA[$];
    int risesA = 0;
    logic prevCsA = 1'b1;
    logic prevSclkA = 1'b0;
    logic busyEverA = 1'b0;
    int fallB[$];
    int validCycB[$];
    logic [7:0] validDatB[$];
    logic prevCsB = 1'b1;
    int ovCycB = -1;

    always @(negedge clk) begin
        if (prevCsA && !csA) fallA.push_back(cyc);
        if (!prevSclkA && sclkA) risesA++;
        if (validA) begin
            validCycA.push_back(cyc);
            validDatA.push_back(audioA);
            risesAtValidA.push_back(risesA);
        end
        if (busyA) busyEverA = 1'b1;
        prevCsA = csA;
        prevSclkA = sclkA;
        if (prevCsB && !csB) fallB.push_back(cyc);
        if (validB) begin
            validCycB.push_back(cyc);
            validDatB.push_back(audioB);
        end
        if (ovrB && ovCycB < 0) ovCycB = cyc;
        prevCsB = csB;
    end

    // Reference: ticks every period from the enable cycle, accepted only if the previous frame is over.
    function automatic int modelFall(input int enCyc, input int period, input int m);
        int lastAcc = -1000000;
        int n = 0;
        for (int t = enCyc; t < enCyc + period * 1000; t += period) begin
            if (t >= lastAcc + FRAME_LEN) begin
                if (n == m) return t + 1;
                lastAcc = t;
                n++;
            end
        end
        return -1;
    endfunction

    function automatic int modelFirstOverrun(input int enCyc, input int period);
        int lastAcc = -1000000;
        for (int t = enCyc; t < enCyc + period * 1000; t += period) begin
            if (t >= lastAcc + FRAME_LEN) lastAcc = t;
            else return t + 1;
        end
        return -1;
    endfunction

    task automatic applyStimulus(input logic rstN, input logic eA, input logic eB);
        rst_n = rstN;
        enA = eA;
        enB = eB;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int eA, eA2, eB, rR, nValid;
    logic [7:0] p1Vals[3] = '{8'hA5, 8'h00, 8'hFF};

    initial begin
        $display("[TB] start");
        #1 applyStimulus(1'b0, 1'b0, 1'b0);
        waitCycles(2);
        checkOutput("rst_cs_n", csA, 1);
        checkOutput("rst_sclk", sclkA, 0);
        checkOutput("rst_audio", audioA, 0);
        checkOutput("rst_valid", validA, 0);
        checkOutput("rst_busy", busyA, 0);
        checkOutput("rst_overrun", ovrA, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);

        waitCycles(200);
        checkOutput("en_low_no_fall", fallA.size(), 0);
        checkOutput("en_low_busy", busyEverA, 0);
        checkOutput("en_low_cs_n", csA, 1);

        planA = '{8'hA5, 8'h00, 8'hFF};
        eA = cyc;
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 500 && validCycA.size() < 3; i++) waitCycles(1);
        checkOutput("p1_valid_count", validCycA.size(), 3);
        if (validCycA.size() >= 3 && fallA.size() >= 3) begin
            for (int m = 0; m < 3; m++) begin
                checkOutput("p1_fall_cycle", fallA[m], modelFall(eA, PA, m));
                checkOutput("p1_latency", validCycA[m] - fallA[m], VALID_LAT);
                checkOutput("p1_data", validDatA[m], p1Vals[m]);
            end
            checkOutput("p1_rises_first", risesAtValidA[0], 8);
            checkOutput("p1_rises_second", risesAtValidA[1] - risesAtValidA[0], 8);
        end
        waitCycles(5);
        checkOutput("hold_audio", audioA, 8'hFF);
        checkOutput("hold_valid", validA, 0);
        checkOutput("p1_overrun", ovrA, 0);

        for (int i = 0; i < 200 && fallA.size() < 4; i++) waitCycles(1);
        checkOutput("p2_fourth_fall", fallA.size(), 4);
        waitCycles(10);
        checkOutput("p2_in_frame_busy", busyA, 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 200 && validCycA.size() < 4; i++) waitCycles(1);
        checkOutput("p2_valid_after_drop", validCycA.size(), 4);
        waitCycles(300);
        checkOutput("p2_no_more_falls", fallA.size(), 4);
        checkOutput("p2_no_more_valids", validCycA.size(), 4);
        checkOutput("p2_cs_high", csA, 1);
        checkOutput("p2_idle", busyA, 0);

        eA2 = cyc;
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10 && fallA.size() < 5; i++) waitCycles(1);
        checkOutput("p3_fall_count", fallA.size(), 5);
        if (fallA.size() >= 5) checkOutput("p3_immediate_start", fallA[4], eA2 + 1);
        for (int i = 0; i < 100 && sclkA !== 1'b1; i++) waitCycles(1);
        checkOutput("p3_sclk_high_before_rst", sclkA, 1);
        nValid = validCycA.size();
        #2 applyStimulus(1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("abort_cs_n", csA, 1);
        checkOutput("abort_sclk", sclkA, 0);
        checkOutput("abort_audio", audioA, 0);
        checkOutput("abort_valid", validA, 0);
        checkOutput("abort_busy", busyA, 0);
        void'(fallA.pop_back());
        void'(expA.pop_back());
        waitCycles(3);
        checkOutput("abort_no_valid", validCycA.size(), nValid);
        rR = cyc;
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 400 && validCycA.size() < nValid + 3; i++) waitCycles(1);
        checkOutput("p3_valid_count", validCycA.size(), nValid + 3);
        checkOutput("p3_fall_count_after", fallA.size(), nValid + 3);
        if (fallA.size() > nValid) checkOutput("p3_restart_fall", fallA[nValid], rR + 1);
        if (validCycA.size() == fallA.size() && expA.size() == fallA.size()) begin
            for (int m = 0; m < validCycA.size(); m++) begin
                checkOutput("all_latency", validCycA[m] - fallA[m], VALID_LAT);
                checkOutput("all_data", validDatA[m], expA[m]);
            end
        end
        checkOutput("a_overrun_end", ovrA, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);

        eB = cyc;
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 600 && validCycB.size() < 3; i++) waitCycles(1);
        checkOutput("b_valid_count", validCycB.size(), 3);
        checkOutput("b_first_overrun", ovCycB, modelFirstOverrun(eB, PB));
        checkOutput("b_overrun_sticky", ovrB, 1);
        if (validCycB.size() >= 3 && fallB.size() >= 3 && expB.size() >= 3) begin
            for (int m = 0; m < 3; m++) begin
                checkOutput("b_fall_cycle", fallB[m], modelFall(eB, PB, m));
                checkOutput("b_latency", validCycB[m] - fallB[m], VALID_LAT);
                checkOutput("b_data", validDatB[m], expB[m]);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
